// File: rtl/ldl_fifo_pkg.sv
// Shared sizing helpers for the ldl FIFO family.
// Level width covers RAM words plus the read in flight and the output buffer.
package ldl_fifo_pkg;

  localparam int unsigned OB_DEPTH = 2;
  localparam int unsigned OB_CW    = 2;
  localparam int unsigned OCW      = OB_CW + 1;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + OB_DEPTH + 1);
  endfunction

endpackage

// File: rtl/ldl_fifo_obuf.sv
// Two-entry registered output buffer that absorbs the RAM read latency.
// dout/valid are registered from next-state values, so there is no path from din.
module ldl_fifo_obuf
  import ldl_fifo_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    din,
  input  logic             pop,
  output logic             valid,
  output logic [DW-1:0]    dout,
  output logic [OB_CW-1:0] count
);

  logic [DW-1:0]    mem   [OB_DEPTH];
  logic [DW-1:0]    mem_n [OB_DEPTH];
  logic             head, head_n;
  logic             tail, tail_n;
  logic [OB_CW-1:0] cnt_n;

  // Next-state: a push into a full buffer only happens alongside a pop of the head slot.
  always_comb begin
    mem_n  = mem;
    head_n = head;
    tail_n = tail;
    cnt_n  = count + OB_CW'(push) - OB_CW'(pop);
    if (push) begin
      mem_n[tail] = din;
      tail_n      = ~tail;
    end
    if (pop) begin
      head_n = ~head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= '{default: '0};
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      mem   <= mem_n;
      head  <= head_n;
      tail  <= tail_n;
      count <= cnt_n;
      valid <= (cnt_n != '0);
      dout  <= mem_n[head_n];
    end
  end

endmodule

// File: rtl/ldl_sfifo_ctrl.sv
// Valid/ready FIFO controller in front of a 1-cycle-read simple dual-port RAM.
// Capacity is DEPTH RAM words plus the 2-entry output buffer.
module ldl_sfifo_ctrl
  import ldl_fifo_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned AW    = addr_w(DEPTH),
  parameter int unsigned CW    = level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] level,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_din,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    ram_cnt;
  logic [CW-1:0]    ram_cnt_n;
  logic             rd_pend;
  logic [OB_CW-1:0] ob_cnt;
  logic [OB_CW-1:0] ob_cnt_n;
  logic [OCW-1:0]   ob_occ;
  logic             wr;
  logic             pop;

  assign wr  = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // Issue a read only when the buffer is guaranteed a free slot when the data lands.
  assign ob_occ = OCW'(ob_cnt) + OCW'(rd_pend) - OCW'(pop);
  assign ram_re = (ram_cnt != '0) & (ob_occ < OCW'(OB_DEPTH));

  assign ram_we  = wr;
  assign ram_wa  = wptr;
  assign ram_din = wr ? in_data : '0;
  assign ram_ra  = rptr;

  assign ram_cnt_n = ram_cnt + CW'(wr) - CW'(ram_re);
  assign ob_cnt_n  = ob_cnt + OB_CW'(rd_pend) - OB_CW'(pop);

  // Pointers wrap by compare so DEPTH need not be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      rd_pend  <= 1'b0;
      in_ready <= 1'b1;
      level    <= '0;
    end else begin
      if (wr) begin
        wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
      end
      if (ram_re) begin
        rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
      end
      ram_cnt  <= ram_cnt_n;
      rd_pend  <= ram_re;
      in_ready <= (ram_cnt_n != FULL);
      level    <= ram_cnt_n + CW'(ram_re) + CW'(ob_cnt_n);
    end
  end

  ldl_fifo_obuf #(
    .DW (DW)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend),
    .din   (ram_dout),
    .pop   (pop),
    .valid (out_valid),
    .dout  (out_data),
    .count (ob_cnt)
  );

endmodule

// File: tb/tb_ldl_sfifo_ctrl.sv
// Bench for ldl_sfifo_ctrl: DEPTH=10 and DEPTH=16 instances share stimulus,
// each tracked by a word-order scoreboard and a held-word count.
module tb_ldl_sfifo_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned D0  = 10;
  localparam int unsigned D1  = 16;
  localparam int unsigned AW0 = $clog2(D0);
  localparam int unsigned CW0 = $clog2(D0 + 3);
  localparam int unsigned AW1 = $clog2(D1);
  localparam int unsigned CW1 = $clog2(D1 + 3);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic out_ready;

  logic in_ready0, out_valid0, ram_we0, ram_re0;
  logic [DW-1:0] out_data0, ram_din0, ram_dout0;
  logic [CW0-1:0] level0;
  logic [AW0-1:0] ram_wa0, ram_ra0;

  logic in_ready1, out_valid1, ram_we1, ram_re1;
  logic [DW-1:0] out_data1, ram_din1, ram_dout1;
  logic [CW1-1:0] level1;
  logic [AW1-1:0] ram_wa1, ram_ra1;

  logic [DW-1:0] mem0 [D0];
  logic [DW-1:0] mem1 [D1];

  logic [DW-1:0] sb [2][65536];
  int unsigned wr_i [2];
  int unsigned rd_i [2];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ldl_sfifo_ctrl #(.DW(DW), .DEPTH(D0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .level(level0),
    .ram_we(ram_we0), .ram_wa(ram_wa0), .ram_din(ram_din0),
    .ram_re(ram_re0), .ram_ra(ram_ra0), .ram_dout(ram_dout0)
  );

  ldl_sfifo_ctrl #(.DW(DW), .DEPTH(D1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .level(level1),
    .ram_we(ram_we1), .ram_wa(ram_wa1), .ram_din(ram_din1),
    .ram_re(ram_re1), .ram_ra(ram_ra1), .ram_dout(ram_dout1)
  );

  // Behavioural RAMs with 1-cycle registered read.
  always @(posedge clk) begin
    if (ram_we0) mem0[ram_wa0] <= ram_din0;
    if (ram_re0) ram_dout0 <= mem0[ram_ra0];
    if (ram_we1) mem1[ram_wa1] <= ram_din1;
    if (ram_re1) ram_dout1 <= mem1[ram_ra1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one instance against the scoreboard, then records this cycle's handshakes.
  task automatic track(input bit idx, input int unsigned dep, input logic ir, input logic ov,
                       input logic [DW-1:0] od, input logic [63:0] lv);
    int unsigned held;
    held = wr_i[idx] - rd_i[idx];
    chk($sformatf("level%0d", idx), lv, 64'(held));
    if (held == 0) chk($sformatf("empty_valid%0d", idx), 64'(ov), 64'(0));
    if (ov === 1'b1 && held != 0)
      chk($sformatf("order%0d", idx), 64'(od), 64'(sb[idx][16'(rd_i[idx])]));
    if (lv == 64'(dep + 2)) chk($sformatf("full_ready%0d", idx), 64'(ir), 64'(0));
    if (in_valid && ir === 1'b1) begin
      sb[idx][16'(wr_i[idx])] = in_data;
      wr_i[idx]++;
    end
    if (out_ready && ov === 1'b1) rd_i[idx]++;
  endtask

  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    track(1'b0, D0, in_ready0, out_valid0, out_data0, 64'(level0));
    track(1'b1, D1, in_ready1, out_valid1, out_data1, 64'(level1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready0), 64'(1));
    chk("rst_out_valid", 64'(out_valid0), 64'(0));
    chk("rst_out_data", 64'(out_data0), 64'(0));
    chk("rst_level", 64'(level0), 64'(0));
    chk("rst_ram_we", 64'(ram_we0), 64'(0));
    chk("rst_ram_re", 64'(ram_re0), 64'(0));
    chk("rst_ram_wa", 64'(ram_wa0), 64'(0));
    chk("rst_ram_ra", 64'(ram_ra0), 64'(0));
    chk("rst_ram_din", 64'(ram_din0), 64'(0));
    chk("rst_level1", 64'(level1), 64'(0));
    chk("rst_out_valid1", 64'(out_valid1), 64'(0));
    for (int i = 0; i < 2; i++) rd_i[i] = wr_i[i];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned t0, t1;
    int n;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    wr_i[0] = 0; wr_i[1] = 0; rd_i[0] = 0; rd_i[1] = 0;

    do_reset();

    // Single word: visible three cycles after its handshake.
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hA5, 1'b1);
    cyc(1'b0, 8'h00, 1'b1); chk("lat_n1_valid", 64'(out_valid0), 64'(0));
    cyc(1'b0, 8'h00, 1'b1); chk("lat_n2_valid", 64'(out_valid0), 64'(0));
    cyc(1'b0, 8'h00, 1'b1);
    chk("lat_n3_valid", 64'(out_valid0), 64'(1));
    chk("lat_n3_data", 64'(out_data0), 64'(8'hA5));
    chk("lat_n3_level", 64'(level0), 64'(1));
    cyc(1'b0, 8'h00, 1'b1);
    chk("lat_n4_valid", 64'(out_valid0), 64'(0));
    chk("lat_n4_level", 64'(level0), 64'(0));

    // Fill DEPTH+2 words with the consumer stalled.
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 8'(k), 1'b0);
      chk("fill_ready", 64'(in_ready0), 64'(1));
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 8'h0C, 1'b0);
      chk("full_ready", 64'(in_ready0), 64'(0));
      chk("full_level", 64'(level0), 64'(12));
    end

    // Drain while refilling: gapless stream, level held at DEPTH+1.
    for (int j = 0; j < 24; j++) begin
      cyc(1'b1, 8'(11 + j), 1'b1);
      chk("drain_valid", 64'(out_valid0), 64'(1));
      chk("drain_data", 64'(out_data0), 64'(8'(j)));
      if (j == 0) chk("drain_ready_j0", 64'(in_ready0), 64'(0));
      if (j >= 1) chk("drain_ready", 64'(in_ready0), 64'(1));
      if (j >= 1) chk("drain_level", 64'(level0), 64'(11));
    end

    // Random traffic until both instances deliver 10000 more words.
    t0 = rd_i[0] + 10000;
    t1 = rd_i[1] + 10000;
    n = 0;
    while ((rd_i[0] < t0 || rd_i[1] < t1) && n < 60000) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      n++;
    end
    chk("random_done", 64'(rd_i[0] >= t0 && rd_i[1] >= t1), 64'(1));

    n = 0;
    while ((wr_i[0] != rd_i[0] || wr_i[1] != rd_i[1]) && n < 200) begin
      cyc(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("drained", 64'(wr_i[0] - rd_i[0]), 64'(0));

    // Reset with 7 words held, then the first post-reset word must lead.
    for (int k = 0; k < 7; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("pre_rst_level", 64'(level0), 64'(7));
    do_reset();
    cyc(1'b1, 8'h3C, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_valid", 64'(out_valid0), 64'(1));
    chk("post_rst_data", 64'(out_data0), 64'(8'h3C));
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_level", 64'(level0), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
